// File: rtl/kyber_pkg.sv
// Shared constants and types for the Kyber polynomial datapath.
package kyber_pkg;
    localparam int KYBER_N        = 256;
    localparam int KYBER_Q        = 3329;
    localparam int BYTES_PER_WORD = 8;
    localparam int WORDS_PER_POLY = KYBER_N / BYTES_PER_WORD;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_DONE
    } feeder_state_t;
endpackage

// File: rtl/byte_lane_packer.sv
// Collect register for one t word: per-lane byte writes plus a bypass view
// that already contains the byte being written this cycle.
module byte_lane_packer
    import kyber_pkg::*;
#(
    parameter int LANES = BYTES_PER_WORD,
    parameter int IDX_W = $clog2(BYTES_PER_WORD)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [7:0]            wr_data,
    output logic [LANES-1:0][7:0] word_full
);
    logic [LANES-1:0][7:0] lanes;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lanes <= '0;
        end else if (wr_en) begin
            lanes[wr_idx] <= wr_data;
        end
    end

    // Bypass lets the last byte complete the word in the same cycle it arrives.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign word_full[g] = (wr_idx == IDX_W'(g)) ? wr_data : lanes[g];
    end
endmodule

// File: rtl/poly_decompress_feeder.sv
// Byte-stream front end: packs 256 coefficient bytes into 32 t words and
// pulses each one to a decompressor that cannot stall.
module poly_decompress_feeder
    import kyber_pkg::*;
#(
    parameter int KYBER_N        = kyber_pkg::KYBER_N,
    parameter int BYTES_PER_WORD = kyber_pkg::BYTES_PER_WORD,
    localparam int WORDS = KYBER_N / BYTES_PER_WORD,
    localparam int BW    = $clog2(BYTES_PER_WORD),
    localparam int WW    = $clog2(WORDS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [7:0]                  s_tdata,
    input  logic                        s_tvalid,
    output logic                        s_tready,
    output logic [8*BYTES_PER_WORD-1:0] t,
    output logic                        t_valid,
    output logic [WW-1:0]               t_index,
    output logic                        t_last,
    output logic                        busy,
    output logic                        done
);
    localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES_PER_WORD - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(WORDS - 1);

    feeder_state_t                    state;
    logic [BW-1:0]                    byte_cnt;
    logic [WW-1:0]                    word_cnt;
    logic                             accept;
    logic [BYTES_PER_WORD-1:0][7:0]   word_full;

    assign accept = s_tvalid && s_tready;

    byte_lane_packer #(
        .LANES (BYTES_PER_WORD),
        .IDX_W (BW)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (accept),
        .wr_idx    (byte_cnt),
        .wr_data   (s_tdata),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            word_cnt <= '0;
            t        <= '0;
            t_valid  <= 1'b0;
            t_index  <= '0;
            t_last   <= 1'b0;
            s_tready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            t_valid <= 1'b0;
            t_last  <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    byte_cnt <= '0;
                    word_cnt <= '0;
                    if (start) begin
                        state    <= ST_FILL;
                        s_tready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == BYTE_LAST) begin
                            t        <= word_full;
                            t_valid  <= 1'b1;
                            t_index  <= word_cnt;
                            t_last   <= (word_cnt == WORD_LAST);
                            word_cnt <= word_cnt + 1'b1;
                            // Drop ready on the same edge so no 257th byte slips in.
                            if (word_cnt == WORD_LAST) begin
                                state    <= ST_DRAIN;
                                s_tready <= 1'b0;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_poly_decompress_feeder.sv
// Directed bench for poly_decompress_feeder with a negedge event logger.
module tb_poly_decompress_feeder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [63:0] t;
    logic        t_valid;
    logic [4:0]  t_index;
    logic        t_last;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    poly_decompress_feeder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .t        (t),
        .t_valid  (t_valid),
        .t_index  (t_index),
        .t_last   (t_last),
        .busy     (busy),
        .done     (done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] tq[$];
    int iq[$], lq[$], vcq[$], accq[$], dq[$];
    int consec = 0;
    int busy_at_done = 0;
    logic prev_tv = 1'b0;

    // Accept during cycle c lands at the edge ending c; its word shows in c+1.
    always @(negedge clk) begin
        if (s_tvalid && s_tready) accq.push_back(cyc);
        if (t_valid) begin
            tq.push_back(t);
            iq.push_back(int'(t_index));
            lq.push_back(int'(t_last));
            vcq.push_back(cyc);
        end
        if (done) begin
            dq.push_back(cyc);
            busy_at_done = int'(busy);
        end
        if (t_valid && prev_tv) consec++;
        prev_tv = t_valid;
    end

    function automatic int dec3(input logic [7:0] b);
        return ((int'(b) & 7) * 3329 + 4) >> 3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        tq.delete(); iq.delete(); lq.delete(); vcq.delete(); accq.delete(); dq.delete();
        consec = 0;
        busy_at_done = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d, input bit gappy);
        int guard = 0;
        if (gappy) repeat ($urandom_range(0, 2)) begin
            s_tvalid = 1'b0;
            @(posedge clk); #1;
        end
        s_tvalid = 1'b1;
        s_tdata  = d;
        while (!s_tready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!s_tready) begin
            chk("tready_timeout", 64'(s_tready), 64'd1);
            s_tvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic run_poly(input bit gappy);
        for (int i = 0; i < 256; i++) push_byte(8'(i % 8), gappy);
        for (int k = 0; k < 40 && dq.size() == 0; k++) begin
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_poly(input string p);
        chk({p, "_nwords"}, 64'(tq.size()), 64'd32);
        chk({p, "_ndone"}, 64'(dq.size()), 64'd1);
        chk({p, "_consec_tv"}, 64'(consec), 64'd0);
        if (tq.size() == 32 && accq.size() == 256) begin
            for (int k = 0; k < 32; k++) begin
                chk($sformatf("%s_t%0d", p, k), tq[k], 64'h0706050403020100);
                chk($sformatf("%s_idx%0d", p, k), 64'(iq[k]), 64'(k));
                chk($sformatf("%s_last%0d", p, k), 64'(lq[k]), 64'(k == 31));
                chk($sformatf("%s_lat%0d", p, k), 64'(vcq[k]), 64'(accq[8*k+7] + 1));
            end
        end
        if (dq.size() > 0 && accq.size() == 256) begin
            chk({p, "_done_cyc"}, 64'(dq[0]), 64'(accq[255] + 2));
            chk({p, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_t", t, 64'd0);
        chk("rst_tvalid", 64'(t_valid), 64'd0);
        chk("rst_tindex", 64'(t_index), 64'd0);
        chk("rst_tlast", 64'(t_last), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back polynomial, byte i = i mod 8.
        clear_logs();
        do_start();
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_tready", 64'(s_tready), 64'd1);
        run_poly(1'b0);
        if (tq.size() > 0) chk("w0_lane7_dec", 64'(dec3(tq[0][63:56])), 64'd2913);
        check_poly("bb");
        chk("post_tready", 64'(s_tready), 64'd0);
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_t_hold", t, 64'h0706050403020100);

        // Same polynomial with random valid gaps.
        clear_logs();
        do_start();
        run_poly(1'b1);
        check_poly("gap");

        // Start pulse mid-transfer must be ignored.
        clear_logs();
        do_start();
        fork
            run_poly(1'b0);
            begin
                for (int k = 0; k < 2000 && tq.size() < 10; k++) @(posedge clk);
                #1;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        check_poly("restart");

        // Reset after 5 bytes of word 3.
        clear_logs();
        do_start();
        for (int i = 0; i < 29; i++) push_byte(8'(i), 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mrst_t", t, 64'd0);
        chk("mrst_tvalid", 64'(t_valid), 64'd0);
        chk("mrst_tindex", 64'(t_index), 64'd0);
        chk("mrst_tlast", 64'(t_last), 64'd0);
        chk("mrst_tready", 64'(s_tready), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("mrst_nwords", 64'(tq.size()), 64'd3);
        chk("mrst_ndone", 64'(dq.size()), 64'd0);

        // Fresh start after reset, all-ones bytes pass unmasked.
        clear_logs();
        do_start();
        for (int i = 0; i < 8; i++) push_byte(8'hFF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("ff_nwords", 64'(tq.size()), 64'd1);
        if (tq.size() > 0) begin
            chk("ff_t", tq[0], 64'hFFFF_FFFF_FFFF_FFFF);
            chk("ff_idx", 64'(iq[0]), 64'd0);
            chk("ff_lane7_dec", 64'(dec3(tq[0][63:56])), 64'd2913);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/poly_decompress_feeder.md
# poly_decompress_feeder

Byte-stream front end for the 3-bit polynomial decompression stage. Accepts one packed polynomial (256 coefficients, one per byte) as a valid/ready byte stream and assembles eight bytes into each 64-bit `t` word. It emits 32 words per polynomial as single-cycle pulses with index and last flags. It sits directly upstream of the decompressor, which registers `t` unconditionally every clock and cannot stall.

## Interface
Parameters:
- `KYBER_N`, 256, coefficients per polynomial.
- `BYTES_PER_WORD`, 8, bytes (coefficients) packed into one `t` word.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: single-cycle request to begin one polynomial. Honoured only in IDLE.
- `s_tdata` in 8: input byte, one coefficient. Only bits [2:0] are significant downstream; all 8 bits are passed through.
- `s_tvalid` in 1: input byte valid.
- `s_tready` out 1: feeder can accept a byte.
- `t` out 64: assembled word. Byte k of the word sits at `t[8k+7:8k]`.
- `t_valid` out 1: `t` holds a new word this cycle. One-cycle pulse per word.
- `t_index` out 5: word number 0..31, valid with `t_valid`.
- `t_last` out 1: high with `t_valid` on word 31 only.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the last word is emitted.

## Operation
- States:
  - IDLE → FILL on `start`.
  - FILL → DRAIN when the 256th byte is accepted.
  - DRAIN → DONE after word 31 is emitted.
  - DONE → IDLE unconditionally.
- IDLE: `s_tready`=0; byte counter and word counter are cleared.
- FILL: `s_tready`=1 continuously.
  - A byte is accepted on `s_tvalid && s_tready` and written into lane `byte_cnt` of the collect register.
  - `byte_cnt` is 3 bits and wraps 7→0.
  - On acceptance with `byte_cnt`==7, the complete word (collect register with lane 7 replaced by the incoming byte) is loaded into `t`, and `t_valid` pulses the next cycle.
  - `word_cnt` increments when the word is emitted.
- DRAIN: `s_tready`=0; only the final word's emission cycle.
- DONE: `done`=1 for one cycle; `busy` drops with it.
- `t` holds its last value between pulses and is never cleared except by reset.
- Collection of the next word proceeds while the previous word is on `t`, so back-to-back input gives one word every 8 cycles with no bubble.
- Gaps in `s_tvalid` stall collection only; partially filled lanes are held.
- `start` while `busy` is ignored, with no effect on counters.
- `rst_n` low in any state: next edge returns to IDLE and clears everything. The partial word is discarded and no `t_valid` or `done` pulse is produced.

## Timing
- Reset values: `t`=0, `t_valid`=0, `t_index`=0, `t_last`=0, `s_tready`=0, `busy`=0, `done`=0.
- `start` at cycle 0: `busy`=1 and `s_tready`=1 at cycle 1.
- 8th byte of a word accepted at edge n: `t`, `t_valid`, `t_index`, `t_last` are valid in cycle n+1. The decompressor's `r` is valid in cycle n+2; the consumer delays `t_valid` by one register.
- Minimum polynomial time with `s_tvalid` held high: 256 accept cycles, then 1 emission cycle, then 1 `done` cycle.
- `t_valid` is never high in consecutive cycles, because the minimum spacing is 8 cycles.

## Structure
- Shared package `kyber_pkg`: `KYBER_N`, `KYBER_Q`, `BYTES_PER_WORD`, `WORDS_PER_POLY` (=`KYBER_N`/`BYTES_PER_WORD`), and the state enum `feeder_state_t`.
- One natural sub-module: `byte_lane_packer`. It holds the collect register, lane write by index, and full-word bypass output. The FSM and counters stay in the top module.

## Test plan
- Reset, then `start` with bytes 0x00..0x07 back-to-back: `t`=0x0706050403020100 with `t_valid`=1, `t_index`=0 one cycle after the 8th accept. Decompressor lane 7 then yields (7·3329+4)>>3 = 2913.
- Full polynomial with byte i = i mod 8, `s_tvalid` held high: exactly 32 `t_valid` pulses spaced 8 cycles apart. `t_index` runs 0..31, `t_last` is high only on index 31, and `done` pulses once 2 cycles after the 256th accept.
- Same polynomial with `s_tvalid` toggled in a random pattern: identical `t` sequence; `t_valid` appears only after each 8th accepted byte.
- `start` pulsed at word 10 of an active transfer: no restart, `t_index` is continuous, one `done`.
- `rst_n` low for one cycle after 5 bytes of word 3: all outputs return to reset values, no further `t_valid`. A new `start` then begins at `t_index` 0.
- Bytes 0xFF×8: `t`=0xFFFFFFFFFFFFFFFF passed unmasked; the downstream lane gives 2913.
